// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared state type, defaults and counter widths for the FFT frame controller
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } fft_state_t;

    localparam int RST_CYCLES_DEF = 4;
    localparam int OUTST_W        = 4;
    localparam int DROP_W         = 16;
    localparam int RCNT_W         = 8;

endpackage

// File: rtl/fft_frame_mon.sv
// rtl/fft_frame_mon.sv - checks FFT core output framing against frames sent, tracks outstanding frames
module fft_frame_mon
    import fft_pkg::*;
#(
    parameter int POW = 11
) (
    input  logic               clk,
    input  logic               aclr_n,
    input  logic               flush_i,
    input  logic               sink_eop_i,
    input  logic               source_sop_i,
    input  logic               source_eop_i,
    input  logic               source_valid_i,
    output logic [OUTST_W-1:0] outstanding_o,
    output logic               frame_done_o,
    output logic               fault_evt_o
);

    logic [POW-1:0]     ocnt_q, ocnt_d;
    logic [OUTST_W-1:0] outst_q, outst_d;
    logic               done_q, done_d;
    logic               inc, dec, sop_bad, eop_bad, eop_orphan, overflow, any_bad;

    always_comb begin
        inc        = sink_eop_i;
        dec        = source_valid_i && source_eop_i;
        sop_bad    = source_valid_i && source_sop_i && (ocnt_q != '0);
        eop_bad    = dec && (ocnt_q != '1);
        eop_orphan = dec && (outst_q == '0);
        overflow   = inc && !dec && (outst_q == '1);
        any_bad    = sop_bad || eop_bad || eop_orphan || overflow;
        fault_evt_o = !flush_i && any_bad;

        ocnt_d  = ocnt_q;
        outst_d = outst_q;
        done_d  = 1'b0;
        if (flush_i) begin
            ocnt_d  = '0;
            outst_d = '0;
        end else begin
            // A returned eop resynchronises the beat counter so one short frame does not poison the next
            if (dec) begin
                ocnt_d = '0;
            end else if (source_valid_i) begin
                ocnt_d = ocnt_q + 1'b1;
            end
            if (inc && !dec && !overflow) begin
                outst_d = outst_q + 1'b1;
            end else if (dec && !inc && !eop_orphan) begin
                outst_d = outst_q - 1'b1;
            end
            done_d = dec && !any_bad;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            ocnt_q  <= '0;
            outst_q <= '0;
            done_q  <= 1'b0;
        end else begin
            ocnt_q  <= ocnt_d;
            outst_q <= outst_d;
            done_q  <= done_d;
        end
    end

    assign outstanding_o = outst_q;
    assign frame_done_o  = done_q;

endmodule

// File: rtl/fft_frame_ctrl.sv
// rtl/fft_frame_ctrl.sv - frames a real sample stream into N-point FFT core input and supervises the core
module fft_frame_ctrl
    import fft_pkg::*;
#(
    parameter int POW        = 11,
    parameter int DATA_WIDTH = 14,
    parameter int RST_CYCLES = RST_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  aclr_n,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_Re,
    output logic                  sink_sop,
    output logic                  sink_eop,
    output logic                  sink_valid,
    output logic [DATA_WIDTH-1:0] sink_Re,
    output logic [DATA_WIDTH-1:0] sink_Im,
    input  logic                  source_sop,
    input  logic                  source_eop,
    input  logic                  source_valid,
    input  logic                  error,
    output logic                  fft_aclr,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  fault,
    output logic [OUTST_W-1:0]    outstanding,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam logic [POW-1:0] LAST_IDX = '1;

    fft_state_t             state_q, state_d;
    logic                   por_q;
    logic [RCNT_W-1:0]      rcnt_q, rcnt_d;
    logic [POW-1:0]         idx_q, idx_d;
    logic                   valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic [DATA_WIDTH-1:0]  re_q, re_d;
    logic                   fault_q, fault_d;
    logic [DROP_W-1:0]      drop_q, drop_d;
    logic                   drop_evt, mon_flush, mon_fault;

    always_comb begin
        state_d  = state_q;
        rcnt_d   = rcnt_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        sop_d    = 1'b0;
        eop_d    = 1'b0;
        re_d     = '0;
        drop_evt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // The power-on cycle is the first of the RST_CYCLES core reset cycles
                if (por_q) begin
                    state_d  = ST_RECOVER;
                    rcnt_d   = RCNT_W'(RST_CYCLES - 2);
                    drop_evt = in_valid;
                end else if (in_valid && enable) begin
                    state_d = ST_RUN;
                    valid_d = 1'b1;
                    sop_d   = 1'b1;
                    re_d    = in_Re;
                    idx_d   = POW'(1);
                end else begin
                    drop_evt = in_valid;
                end
            end
            ST_RUN: begin
                if (in_valid) begin
                    valid_d = 1'b1;
                    re_d    = in_Re;
                    sop_d   = (idx_q == '0);
                    eop_d   = (idx_q == LAST_IDX);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == LAST_IDX && !enable) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RECOVER: begin
                drop_evt = in_valid;
                if (rcnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = rcnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (error) begin
            state_d = ST_RECOVER;
            rcnt_d  = RCNT_W'(RST_CYCLES - 1);
            idx_d   = '0;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            re_d    = '0;
        end
    end

    always_comb begin
        fault_d = fault_q;
        if (clear) begin
            fault_d = 1'b0;
        end
        if (mon_fault || error) begin
            fault_d = 1'b1;
        end
        drop_d = drop_q;
        if (clear) begin
            drop_d = '0;
        end else if (drop_evt && drop_q != '1) begin
            drop_d = drop_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state_q <= ST_IDLE;
            por_q   <= 1'b1;
            rcnt_q  <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            re_q    <= '0;
            fault_q <= 1'b0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            por_q   <= 1'b0;
            rcnt_q  <= rcnt_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            re_q    <= re_d;
            fault_q <= fault_d;
            drop_q  <= drop_d;
        end
    end

    // Anything the core emits while it is held in reset is ignored rather than judged
    assign mon_flush = error || por_q || (state_q == ST_RECOVER);

    fft_frame_mon #(
        .POW(POW)
    ) u_mon (
        .clk            (clk),
        .aclr_n         (aclr_n),
        .flush_i        (mon_flush),
        .sink_eop_i     (valid_q && eop_q),
        .source_sop_i   (source_sop),
        .source_eop_i   (source_eop),
        .source_valid_i (source_valid),
        .outstanding_o  (outstanding),
        .frame_done_o   (frame_done),
        .fault_evt_o    (mon_fault)
    );

    assign sink_valid = valid_q;
    assign sink_sop   = sop_q;
    assign sink_eop   = eop_q;
    assign sink_Re    = re_q;
    assign sink_Im    = '0;
    assign fft_aclr   = por_q || (state_q == ST_RECOVER);
    assign busy       = (state_q != ST_IDLE);
    assign fault      = fault_q;
    assign drop_cnt   = drop_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// tb/tb_fft_frame_ctrl.sv - self-checking bench for fft_frame_ctrl with a sample scoreboard and core model
module tb_fft_frame_ctrl;

    localparam int POW = 4;
    localparam int N   = 16;
    localparam int DW  = 14;

    logic          clk = 1'b0;
    logic          aclr_n = 1'b0;
    logic          enable = 1'b0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_Re = '0;
    logic          sink_sop, sink_eop, sink_valid;
    logic [DW-1:0] sink_Re, sink_Im;
    logic          source_sop = 1'b0;
    logic          source_eop = 1'b0;
    logic          source_valid = 1'b0;
    logic          error = 1'b0;
    logic          fft_aclr, busy, frame_done, fault;
    logic [3:0]    outstanding;
    logic [15:0]   drop_cnt;

    int total = 0;
    int bad = 0;
    int model_idx = 0;
    int done_seen = 0;

    typedef struct packed {
        logic          sop;
        logic          eop;
        logic [DW-1:0] re;
    } samp_t;

    typedef struct {
        int   beats;
        int   exp_done;
        logic exp_fault;
        int   exp_out;
    } core_vec_t;

    samp_t     exp_q[$];
    samp_t     cur;
    core_vec_t cv[4];

    always #5 clk = ~clk;

    fft_frame_ctrl #(
        .POW(POW),
        .DATA_WIDTH(DW),
        .RST_CYCLES(4)
    ) dut (
        .clk          (clk),
        .aclr_n       (aclr_n),
        .enable       (enable),
        .clear        (clear),
        .in_valid     (in_valid),
        .in_Re        (in_Re),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_valid   (sink_valid),
        .sink_Re      (sink_Re),
        .sink_Im      (sink_Im),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_valid (source_valid),
        .error        (error),
        .fft_aclr     (fft_aclr),
        .busy         (busy),
        .frame_done   (frame_done),
        .fault        (fault),
        .outstanding  (outstanding),
        .drop_cnt     (drop_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (aclr_n && sink_valid) begin
            if (exp_q.size() == 0) begin
                check("sink_valid_unexpected", {31'd0, sink_valid}, 32'd0);
            end else begin
                cur = exp_q.pop_front();
                check("sink_sample", {2'b00, sink_sop, sink_eop, sink_Im, sink_Re},
                      {2'b00, cur.sop, cur.eop, {DW{1'b0}}, cur.re});
            end
        end
        if (frame_done) done_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] re);
        samp_t s;
        s.sop = (model_idx == 0);
        s.eop = (model_idx == N - 1);
        s.re  = re;
        exp_q.push_back(s);
        model_idx = (model_idx + 1) % N;
        in_valid = 1'b1;
        in_Re    = re;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drop_sample(input logic [DW-1:0] re);
        in_valid = 1'b1;
        in_Re    = re;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic core_frame(input int beats);
        for (int b = 0; b < beats; b++) begin
            source_valid = 1'b1;
            source_sop   = (b == 0);
            source_eop   = (b == beats - 1);
            tick();
        end
        source_valid = 1'b0;
        source_sop   = 1'b0;
        source_eop   = 1'b0;
    endtask

    task automatic count_aclr(output int cnt);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fft_aclr) cnt++;
            else break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int done_before;

        cv[0].beats = 16; cv[0].exp_done = 1; cv[0].exp_fault = 1'b0; cv[0].exp_out = 3;
        cv[1].beats = 16; cv[1].exp_done = 1; cv[1].exp_fault = 1'b0; cv[1].exp_out = 2;
        cv[2].beats = 16; cv[2].exp_done = 1; cv[2].exp_fault = 1'b0; cv[2].exp_out = 1;
        cv[3].beats = 16; cv[3].exp_done = 1; cv[3].exp_fault = 1'b0; cv[3].exp_out = 0;

        #12;
        check("rst_fft_aclr", fft_aclr, 1);
        check("rst_busy", busy, 0);
        check("rst_sink_valid", sink_valid, 0);
        check("rst_fault", fault, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_frame_done", frame_done, 0);

        tick();
        aclr_n = 1'b1;
        count_aclr(n);
        check("por_aclr_cycles", n, 4);
        check("por_fault", fault, 0);
        check("por_busy", busy, 0);

        // two continuous frames, the second with a 3-cycle gap holding index 7
        enable = 1'b1;
        model_idx = 0;
        for (int i = 0; i < N; i++) send(DW'(100 + i));
        for (int i = 0; i < 7; i++) send(DW'(200 + i));
        for (int g = 0; g < 3; g++) begin
            tick();
            @(negedge clk);
            check("gap_sink_valid", sink_valid, 0);
        end
        for (int i = 7; i < N; i++) send(DW'(200 + i));

        // enable dropped mid-frame: frame completes, then samples are dropped
        for (int i = 0; i < 5; i++) send(DW'(300 + i));
        enable = 1'b0;
        for (int i = 5; i < N; i++) send(DW'(300 + i));
        for (int i = 0; i < 10; i++) drop_sample(DW'(i));
        check("idle_busy", busy, 0);
        check("drop_cnt_10", drop_cnt, 10);
        check("outstanding_3", outstanding, 3);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_drop_cnt", drop_cnt, 0);

        enable = 1'b1;
        model_idx = 0;
        for (int i = 0; i < N - 1; i++) send(DW'(400 + i));
        enable = 1'b0;
        send(DW'(415));
        tick();
        check("outstanding_4", outstanding, 4);

        for (int r = 0; r < 4; r++) begin
            done_before = done_seen;
            core_frame(cv[r].beats);
            tick();
            tick();
            check("core_done", done_seen - done_before, cv[r].exp_done);
            check("core_fault", fault, cv[r].exp_fault);
            check("core_outstanding", outstanding, cv[r].exp_out);
        end

        // error mid-frame with one frame outstanding
        enable = 1'b1;
        model_idx = 0;
        for (int i = 0; i < N; i++) send(DW'(500 + i));
        for (int i = 0; i < 6; i++) send(DW'(600 + i));
        check("pre_err_outstanding", outstanding, 1);
        error = 1'b1;
        tick();
        error = 1'b0;
        count_aclr(n);
        check("err_aclr_cycles", n, 4);
        check("err_fault", fault, 1);
        check("err_outstanding", outstanding, 0);
        check("err_busy_after", busy, 0);

        model_idx = 0;
        for (int i = 0; i < N - 1; i++) send(DW'(700 + i));
        enable = 1'b0;
        send(DW'(715));
        tick();
        check("post_err_outstanding", outstanding, 1);

        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clear_fault", fault, 0);

        // short output frame: eop after 12 beats
        done_before = done_seen;
        core_frame(12);
        tick();
        tick();
        check("short_done", done_seen - done_before, 0);
        check("short_fault", fault, 1);
        check("short_outstanding", outstanding, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("short_clear_fault", fault, 0);

        // error outranks clear in the same cycle
        error = 1'b1;
        clear = 1'b1;
        tick();
        error = 1'b0;
        clear = 1'b0;
        check("err_over_clear", fault, 1);
        check("err_over_clear_aclr", fft_aclr, 1);
        repeat (6) tick();
        check("err_over_clear_idle", busy, 0);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
